// File: rtl/fixed_to_float_seq.sv
// Sequential signed fixed-point to IEEE-754-style float converter.
// Normalizes one bit per clock, then rounds to nearest-even and saturates or flushes the exponent.
module fixed_to_float_seq #(
    parameter int FLOATSIZE      = 32,
    parameter int FIXEDSIZE      = 32,
    parameter int RADIXPOINTSIZE = 6,
    parameter int EXPONENTBITS   = 8,
    parameter int MANTISSABITS   = 23,
    parameter int BIAS           = 2**(EXPONENTBITS-1)-1
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      InStart,
    input  logic [FIXEDSIZE-1:0]      InFixed,
    input  logic [RADIXPOINTSIZE-1:0] InRadixPoint,
    output logic [FLOATSIZE-1:0]      OutFloat,
    output logic                      OutDone,
    output logic                      OutBusy,
    output logic                      OutOverflow,
    output logic                      OutUnderflow
);
    localparam int N   = FIXEDSIZE;
    localparam int M   = MANTISSABITS;
    localparam int E   = EXPONENTBITS;
    localparam int LZW = $clog2(N);
    localparam int EBW = E + 3;
    localparam int MW1 = M + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] NORM  = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;

    localparam logic signed [EBW-1:0] EXP_MAX  = EBW'((2**E) - 1);
    localparam logic signed [EBW-1:0] EXP_ZERO = '0;

    logic [1:0]                state;
    logic                      sign;
    logic [N-1:0]              mag;
    logic [LZW-1:0]            lz;
    logic [RADIXPOINTSIZE-1:0] radix;

    logic [N-1:0]              abs_in;
    logic [M-1:0]              mant;
    logic                      guard;
    logic                      sticky;
    logic signed [EBW-1:0]     exp_unb;
    logic signed [EBW-1:0]     exp_bias;
    logic signed [EBW-1:0]     exp_rnd;
    logic [M:0]                mant_sum;
    logic [M-1:0]              mant_rnd;
    logic                      round_up;
    logic [FLOATSIZE-1:0]      next_float;
    logic                      next_ovf;
    logic                      next_unf;

    // Two's-complement negation of the most-negative value yields 2^(N-1), which is its true magnitude.
    assign abs_in  = InFixed[N-1] ? -InFixed : InFixed;
    assign OutBusy = (state == NORM) || (state == ROUND);

    generate
        if (N - 1 > M) begin : g_round
            assign mant  = mag[N-2 -: M];
            assign guard = mag[N-2-M];
            if (N - 2 - M > 0) begin : g_sticky
                assign sticky = |mag[N-3-M:0];
            end else begin : g_no_sticky
                assign sticky = 1'b0;
            end
        end else begin : g_pad
            assign mant   = M'(mag[N-2:0]) << (M - N + 1);
            assign guard  = 1'b0;
            assign sticky = 1'b0;
        end
    endgenerate

    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        next_float = '0;
        next_ovf   = 1'b0;
        next_unf   = 1'b0;
        exp_unb    = EBW'(N - 1) - EBW'(lz) - EBW'(radix);
        exp_bias   = exp_unb + EBW'(BIAS);
        round_up   = guard & (sticky | mant[0]);
        mant_sum   = {1'b0, mant} + MW1'(round_up);
        exp_rnd    = exp_bias + EBW'(mant_sum[M]);
        mant_rnd   = mant_sum[M] ? '0 : mant_sum[M-1:0];
        if (mag == '0) begin
            next_float = '0;
        end else if (exp_rnd >= EXP_MAX) begin
            next_float = {sign, {E{1'b1}}, {M{1'b0}}};
            next_ovf   = 1'b1;
        end else if (exp_rnd <= EXP_ZERO) begin
            next_float = {sign, {E{1'b0}}, {M{1'b0}}};
            next_unf   = 1'b1;
        end else begin
            next_float = {sign, exp_rnd[E-1:0], mant_rnd};
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state        <= IDLE;
            sign         <= 1'b0;
            mag          <= '0;
            lz           <= '0;
            radix        <= '0;
            OutFloat     <= '0;
            OutDone      <= 1'b0;
            OutOverflow  <= 1'b0;
            OutUnderflow <= 1'b0;
        end else begin
            OutDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (InStart) begin
                        sign  <= InFixed[N-1];
                        mag   <= abs_in;
                        radix <= InRadixPoint;
                        lz    <= '0;
                        state <= (abs_in == '0 || abs_in[N-1]) ? ROUND : NORM;
                    end
                end
                NORM: begin
                    // Leave on the shift that sets the MSB, so ROUND follows 1+Lz edges after start.
                    mag <= mag << 1;
                    lz  <= lz + LZW'(1);
                    if (mag[N-2]) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    OutFloat     <= next_float;
                    OutOverflow  <= next_ovf;
                    OutUnderflow <= next_unf;
                    OutDone      <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_to_float_seq.sv
// Self-checking bench: directed vectors, busy/reset sequences and random stimulus vs a numeric model.
module tb_fixed_to_float_seq;
    logic        Clk = 1'b0;
    logic        Rst;
    logic        InStart;
    logic [31:0] InFixed;
    logic [5:0]  InRadixPoint;

    logic [31:0] float_a;
    logic        done_a, busy_a, ovf_a, unf_a;
    logic [15:0] float_b;
    logic        done_b, busy_b, ovf_b, unf_b;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    fixed_to_float_seq dut_a (
        .Clk(Clk), .Rst(Rst), .InStart(InStart), .InFixed(InFixed), .InRadixPoint(InRadixPoint),
        .OutFloat(float_a), .OutDone(done_a), .OutBusy(busy_a),
        .OutOverflow(ovf_a), .OutUnderflow(unf_a)
    );

    fixed_to_float_seq #(.FLOATSIZE(16), .EXPONENTBITS(5), .MANTISSABITS(10)) dut_b (
        .Clk(Clk), .Rst(Rst), .InStart(InStart), .InFixed(InFixed), .InRadixPoint(InRadixPoint),
        .OutFloat(float_b), .OutDone(done_b), .OutBusy(busy_b),
        .OutOverflow(ovf_b), .OutUnderflow(unf_b)
    );

    typedef struct {
        logic [31:0] fx;
        logic [5:0]  rp;
        bit          use_b;
        logic [31:0] exp_f;
        bit          exp_o;
        bit          exp_u;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Value-level reference: locate the leading one, scale, round half-to-even, then classify.
    function automatic void model(input logic [31:0] fx, input int rp, input int e_bits,
                                  input int m_bits, output logic [63:0] res, output bit ovf,
                                  output bit unf, output int lat);
        longint mag, q, rem, half, one, s;
        int p, e, eb, sh;
        one = 1;
        s   = longint'(fx[31]);
        mag = fx[31] ? (one << 32) - longint'(fx) : longint'(fx);
        res = '0; ovf = 0; unf = 0; lat = 2;
        if (mag == 0) return;
        p = 0;
        for (int i = 0; i < 33; i++) if (mag >= (one << i)) p = i;
        lat = 2 + 31 - p;
        e   = p - rp;
        if (p > m_bits) begin
            sh   = p - m_bits;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = one << (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
            if (q == (one << (m_bits + 1))) begin
                q = q >> 1;
                e++;
            end
        end else begin
            q = mag << (m_bits - p);
        end
        eb = e + 2**(e_bits-1) - 1;
        if (eb >= 2**e_bits - 1) begin
            res = (s << (e_bits + m_bits)) | (((one << e_bits) - 1) << m_bits);
            ovf = 1;
        end else if (eb <= 0) begin
            res = s << (e_bits + m_bits);
            unf = 1;
        end else begin
            res = (s << (e_bits + m_bits)) | (longint'(eb) << m_bits) | (q - (one << m_bits));
        end
    endfunction

    // Called just after a rising edge; lat counts the start-sampling edge as edge 1.
    task automatic convert(input logic [31:0] fx, input logic [5:0] rp, output int lat,
                           output bit busy_ok);
        InFixed      = fx;
        InRadixPoint = rp;
        InStart      = 1'b1;
        @(posedge Clk); #1;
        InStart = 1'b0;
        lat     = 1;
        busy_ok = 1;
        while (!done_a && lat < 40) begin
            if (!busy_a || !busy_b) busy_ok = 0;
            @(posedge Clk); #1;
            lat++;
        end
        if (!done_a) lat = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[10];
        int          lat, ndone, first;
        bit          busy_ok, m_o, m_u;
        logic [63:0] m_f;
        logic [31:0] fx;
        logic [5:0]  rp;

        vecs[0] = '{32'h0000_0001, 6'd0,  0, 32'h3F80_0000, 0, 0, 33};
        vecs[1] = '{32'hFFFF_FFFF, 6'd0,  0, 32'hBF80_0000, 0, 0, 33};
        vecs[2] = '{32'h8000_0000, 6'd0,  0, 32'hCF00_0000, 0, 0, 2};
        vecs[3] = '{32'h7FFF_FFFF, 6'd0,  0, 32'h4F00_0000, 0, 0, 3};
        vecs[4] = '{32'h0100_0001, 6'd0,  0, 32'h4B80_0000, 0, 0, 9};
        vecs[5] = '{32'h0000_0001, 6'd40, 0, 32'h2B80_0000, 0, 0, 33};
        vecs[6] = '{32'h0000_0000, 6'd17, 0, 32'h0000_0000, 0, 0, 2};
        vecs[7] = '{32'h4000_0000, 6'd0,  1, 32'h0000_7C00, 1, 0, 3};
        vecs[8] = '{32'h0000_0001, 6'd30, 1, 32'h0000_0000, 0, 1, 33};
        vecs[9] = '{32'h0000_0000, 6'd63, 1, 32'h0000_0000, 0, 0, 2};

        Rst = 1'b1; InStart = 1'b0; InFixed = '0; InRadixPoint = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_float_a", float_a, 0);
        check("reset_float_b", float_b, 0);
        check("reset_ctrl", {done_a, busy_a, ovf_a, unf_a, done_b, busy_b, ovf_b, unf_b}, 0);
        Rst = 1'b0;
        @(posedge Clk); #1;

        for (int i = 0; i < 10; i++) begin
            convert(vecs[i].fx, vecs[i].rp, lat, busy_ok);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_busy", i), busy_ok, 1);
            if (vecs[i].use_b) begin
                check($sformatf("vec%0d_float", i), float_b, vecs[i].exp_f);
                check($sformatf("vec%0d_flags", i), {ovf_b, unf_b}, {vecs[i].exp_o, vecs[i].exp_u});
            end else begin
                check($sformatf("vec%0d_float", i), float_a, vecs[i].exp_f);
                check($sformatf("vec%0d_flags", i), {ovf_a, unf_a}, {vecs[i].exp_o, vecs[i].exp_u});
            end
        end

        // Start pulsed while busy must be ignored.
        InFixed = 32'h0000_0001; InRadixPoint = 6'd0; InStart = 1'b1;
        @(posedge Clk); #1;
        InStart = 1'b0;
        ndone = 0;
        first = -1;
        for (int k = 2; k <= 45; k++) begin
            if (k == 6) begin
                InFixed = 32'h8000_0000;
                InStart = 1'b1;
            end else begin
                InStart = 1'b0;
            end
            @(posedge Clk); #1;
            if (done_a) begin
                ndone++;
                if (first < 0) first = k;
            end
        end
        check("busy_start_ndone", ndone, 1);
        check("busy_start_lat", first, 33);
        check("busy_start_float", float_a, 32'h3F80_0000);

        // Reset asserted mid-normalization clears everything immediately.
        InFixed = 32'h0000_0001; InRadixPoint = 6'd0; InStart = 1'b1;
        @(posedge Clk); #1;
        InStart = 1'b0;
        repeat (5) @(posedge Clk);
        #2 Rst = 1'b1;
        #1;
        check("midreset_float_a", float_a, 0);
        check("midreset_float_b", float_b, 0);
        check("midreset_ctrl", {done_a, busy_a, ovf_a, unf_a, done_b, busy_b, ovf_b, unf_b}, 0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(posedge Clk); #1;
        convert(32'h0000_0002, 6'd0, lat, busy_ok);
        check("after_reset_lat", lat, 32);
        check("after_reset_float_a", float_a, 32'h4000_0000);
        check("after_reset_float_b", float_b, 16'h4000);

        for (int n = 0; n < 150; n++) begin
            fx = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) fx = -fx;
            rp = 6'($urandom_range(0, 63));
            convert(fx, rp, lat, busy_ok);
            model(fx, int'(rp), 8, 23, m_f, m_o, m_u, first);
            check($sformatf("rnd%0d_lat fx=%h rp=%0d", n, fx, rp), lat, first);
            check($sformatf("rnd%0d_float_a fx=%h rp=%0d", n, fx, rp), float_a, m_f);
            check($sformatf("rnd%0d_flags_a", n), {ovf_a, unf_a}, {m_o, m_u});
            model(fx, int'(rp), 5, 10, m_f, m_o, m_u, first);
            check($sformatf("rnd%0d_done_b", n), done_b, 1);
            check($sformatf("rnd%0d_float_b fx=%h rp=%0d", n, fx, rp), float_b, m_f);
            check($sformatf("rnd%0d_flags_b", n), {ovf_b, unf_b}, {m_o, m_u});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
